// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector write path.
// FSM encodings and sector geometry.
package sd_pkg;

  localparam int SEC_HW    = 256;
  localparam int DW_DEF    = 32;
  localparam int SEC_WORDS = SEC_HW * 16 / DW_DEF;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_DATA = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_XFER      = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

endpackage

// File: rtl/sd_write_sectors_word_to_hw.sv
// 32->16 halfword splitter feeding the SD write port.
// High half goes out first; the word is popped on the low half.
module sd_word_to_hw
  import sd_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          wr_req,
  input  logic          room,
  input  logic [DW-1:0] fifo_rd_data,
  input  logic          fifo_empty,
  output logic [15:0]   wr_data,
  output logic          fifo_rd_en,
  output logic          underrun
);

  logic hw_sel;
  logic take;

  assign take       = en & wr_req & room;
  assign fifo_rd_en = take & hw_sel & ~fifo_empty;
  assign underrun   = take & hw_sel & fifo_empty;

  // Halfword select and registered output data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_sel  <= 1'b0;
      wr_data <= 16'd0;
    end else if (clr) begin
      hw_sel  <= 1'b0;
    end else if (take) begin
      hw_sel  <= ~hw_sel;
      wr_data <= hw_sel ? fifo_rd_data[15:0]
                        : fifo_rd_data[31:16];
    end
  end

endmodule

// File: rtl/sd_write_sectors.sv
// DMA-driven multi-sector SD writer (clk_50m domain).
// Waits for a full sector in the FIFO, then streams it.
module sd_write_sectors
  import sd_pkg::*;
#(
  parameter int DW     = 32,
  parameter int SEC_HW = 256,
  parameter int LVL_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      dma_sec_addr,
  input  logic [31:0]      dma_sec_counts,
  input  logic             dma_sd_write,
  input  logic [DW-1:0]    fifo_rd_data,
  input  logic             fifo_empty,
  input  logic [LVL_W-1:0] fifo_level,
  output logic             fifo_rd_en,
  input  logic             wr_busy,
  input  logic             wr_req,
  output logic             wr_start_en,
  output logic [31:0]      wr_sec_addr,
  output logic [15:0]      wr_data,
  output logic             Write_finish,
  output logic             wr_err
);

  localparam int WORDS = SEC_HW * 16 / DW;
  localparam int CW    = $clog2(SEC_HW + 1);

  state_t        state;
  state_t        state_nxt;
  logic          start_q;
  logic          busy_q;
  logic [31:0]   cur_addr;
  logic [31:0]   remain;
  logic [CW-1:0] hw_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          start_rise;
  logic          busy_fall;
  logic          in_xfer;
  logic          room;
  logic          req_ok;
  logic          over;
  logic          lvl_ok;
  logic          underrun;
  logic          short_sec;

  assign start_rise = dma_sd_write & ~start_q &
                      (state == S_IDLE ||
                       state == S_DONE);
  assign busy_fall  = busy_q & ~wr_busy;
  assign in_xfer    = (state == S_XFER);
  assign room       = (hw_cnt != CW'(SEC_HW));
  assign req_ok     = in_xfer & wr_req & room;
  assign over       = in_xfer & wr_req & ~room;
  assign cnt_nxt    = hw_cnt + CW'(req_ok);
  assign lvl_ok     = (fifo_level >= LVL_W'(WORDS));
  assign short_sec  = in_xfer & busy_fall &
                      (cnt_nxt != CW'(SEC_HW));

  // Sector sequencing
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE:
        if (start_rise)
          state_nxt = (dma_sec_counts == 32'd0)
                    ? S_DONE : S_WAIT_DATA;
      S_WAIT_DATA:
        if (lvl_ok) state_nxt = S_START;
      S_START:
        state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY:
        if (wr_busy) state_nxt = S_XFER;
      S_XFER:
        if (busy_fall)
          state_nxt = (remain == 32'd1)
                    ? S_DONE : S_WAIT_DATA;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // State, job bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      cur_addr     <= 32'd0;
      remain       <= 32'd0;
      hw_cnt       <= '0;
      wr_start_en  <= 1'b0;
      wr_sec_addr  <= 32'd0;
      Write_finish <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_q     <= dma_sd_write;
      busy_q      <= wr_busy;
      wr_start_en <= (state_nxt == S_START);
      if (start_rise) begin
        cur_addr <= dma_sec_addr;
        remain   <= dma_sec_counts;
      end else if (in_xfer && busy_fall) begin
        cur_addr <= cur_addr + 32'd1;
        remain   <= remain - 32'd1;
      end
      if (state == S_WAIT_DATA && lvl_ok)
        wr_sec_addr <= cur_addr;
      if (state == S_START)
        hw_cnt <= '0;
      else
        hw_cnt <= cnt_nxt;
      if (start_rise)
        Write_finish <= 1'b0;
      else if (state_nxt == S_DONE)
        Write_finish <= 1'b1;
      if (start_rise)
        wr_err <= 1'b0;
      else if (over || underrun || short_sec)
        wr_err <= 1'b1;
    end
  end

  sd_word_to_hw #(.DW(DW)) u_split (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (state == S_START),
    .en           (in_xfer),
    .wr_req       (wr_req),
    .room         (room),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .wr_data      (wr_data),
    .fifo_rd_en   (fifo_rd_en),
    .underrun     (underrun)
  );

endmodule

// File: tb/tb_sd_write_sectors.sv
// Directed bench for sd_write_sectors with an FWFT FIFO
// model and a simple sd_ctrl_top write-side model.
module tb_sd_write_sectors;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dma_sec_addr;
  logic [31:0] dma_sec_counts;
  logic        dma_sd_write;
  logic [31:0] fifo_rd_data;
  logic        fifo_empty;
  logic [9:0]  fifo_level;
  logic        fifo_rd_en;
  logic        wr_busy;
  logic        wr_req;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic [15:0] wr_data;
  logic        Write_finish;
  logic        wr_err;

  always #5 clk = ~clk;

  sd_write_sectors #(.DW(32), .SEC_HW(256), .LVL_W(10)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dma_sec_addr   (dma_sec_addr),
    .dma_sec_counts (dma_sec_counts),
    .dma_sd_write   (dma_sd_write),
    .fifo_rd_data   (fifo_rd_data),
    .fifo_empty     (fifo_empty),
    .fifo_level     (fifo_level),
    .fifo_rd_en     (fifo_rd_en),
    .wr_busy        (wr_busy),
    .wr_req         (wr_req),
    .wr_start_en    (wr_start_en),
    .wr_sec_addr    (wr_sec_addr),
    .wr_data        (wr_data),
    .Write_finish   (Write_finish),
    .wr_err         (wr_err)
  );

  logic [31:0] mem [0:1023];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int n_start = 0;
  int n_pop = 0;

  assign fifo_rd_data = mem[rd_ptr % 1024];
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_level   = 10'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (wr_start_en) n_start <= n_start + 1;
    if (fifo_rd_en) begin
      n_pop  <= n_pop + 1;
      rd_ptr <= rd_ptr + 1;
    end
  end

  int errors = 0;
  int checks = 0;
  logic [15:0] got [0:299];
  logic [31:0] got_addr;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input int n, input int b);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 1024] = {16'(b + 2 * i),
                            16'(b + 2 * i + 1)};
      wr_ptr++;
    end
  endtask

  task automatic start_job(input logic [31:0] a,
                           input logic [31:0] c);
    @(negedge clk);
    dma_sec_addr   = a;
    dma_sec_counts = c;
    dma_sd_write   = 1'b1;
    @(negedge clk);
    dma_sd_write   = 1'b0;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 4000 && wr_start_en !== 1'b1; i++)
      @(negedge clk);
    check("start_seen", 64'(wr_start_en), 64'd1);
    got_addr = wr_sec_addr;
  endtask

  task automatic sd_sector(input int nreq, input int eb,
                           input bit mid,
                           output int bad);
    bad = 0;
    wait_start();
    @(negedge clk);
    wr_busy = 1'b1;
    for (int k = 0; k < nreq; k++) begin
      @(negedge clk);
      wr_req = 1'b1;
      if (mid && k == 50) dma_sd_write = 1'b1;
      if (mid && k == 60) dma_sd_write = 1'b0;
      @(negedge clk);
      wr_req = 1'b0;
      got[k] = wr_data;
      if (k < 256 && wr_data !== 16'(eb + k)) bad++;
    end
    @(negedge clk);
    wr_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int bad;
    int s0;
    int p0;
    logic [31:0] a0;
    logic [31:0] a1;
    rst_n          = 1'b0;
    dma_sec_addr   = 32'd0;
    dma_sec_counts = 32'd0;
    dma_sd_write   = 1'b0;
    wr_busy        = 1'b0;
    wr_req         = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start", 64'(wr_start_en), 64'd0);
    check("rst_pop", 64'(fifo_rd_en), 64'd0);
    check("rst_fin", 64'(Write_finish), 64'd0);
    check("rst_err", 64'(wr_err), 64'd0);
    check("rst_data", 64'(wr_data), 64'd0);
    check("rst_addr", 64'(wr_sec_addr), 64'd0);
    rst_n = 1'b1;

    // single sector
    push(128, 1);
    s0 = n_start;
    p0 = n_pop;
    start_job(32'h100, 32'd1);
    sd_sector(256, 1, 1'b0, bad);
    check("s1_addr", 64'(got_addr), 64'h100);
    check("s1_d0", 64'(got[0]), 64'h0001);
    check("s1_d1", 64'(got[1]), 64'h0002);
    check("s1_d255", 64'(got[255]), 64'h0100);
    check("s1_bad", 64'(bad), 64'd0);
    check("s1_nstart", 64'(n_start - s0), 64'd1);
    check("s1_npop", 64'(n_pop - p0), 64'd128);
    check("s1_fin", 64'(Write_finish), 64'd1);
    check("s1_err", 64'(wr_err), 64'd0);

    // three sectors across the address wrap
    push(384, 16'h0400);
    s0 = n_start;
    start_job(32'hFFFF_FFFE, 32'd3);
    check("m_fin_clr", 64'(Write_finish), 64'd0);
    sd_sector(256, 16'h0400, 1'b0, bad);
    a0 = got_addr;
    check("m_bad0", 64'(bad), 64'd0);
    sd_sector(256, 16'h0500, 1'b0, bad);
    a1 = got_addr;
    check("m_bad1", 64'(bad), 64'd0);
    check("m_fin_mid", 64'(Write_finish), 64'd0);
    sd_sector(256, 16'h0600, 1'b0, bad);
    check("m_bad2", 64'(bad), 64'd0);
    check("m_a0", 64'(a0), 64'hFFFF_FFFE);
    check("m_a1", 64'(a1), 64'hFFFF_FFFF);
    check("m_a2", 64'(got_addr), 64'h0);
    check("m_nstart", 64'(n_start - s0), 64'd3);
    check("m_fin", 64'(Write_finish), 64'd1);
    check("m_err", 64'(wr_err), 64'd0);

    // data starvation between sectors
    push(128, 16'h0800);
    s0 = n_start;
    start_job(32'h40, 32'd2);
    sd_sector(256, 16'h0800, 1'b0, bad);
    check("st_bad0", 64'(bad), 64'd0);
    repeat (1000) @(negedge clk);
    check("st_hold", 64'(n_start - s0), 64'd1);
    check("st_fin0", 64'(Write_finish), 64'd0);
    push(128, 16'h0900);
    sd_sector(256, 16'h0900, 1'b0, bad);
    check("st_bad1", 64'(bad), 64'd0);
    check("st_a1", 64'(got_addr), 64'h41);
    check("st_fin", 64'(Write_finish), 64'd1);
    check("st_err", 64'(wr_err), 64'd0);

    // one request too many
    push(129, 16'h1000);
    p0 = n_pop;
    start_job(32'h10, 32'd1);
    sd_sector(257, 16'h1000, 1'b0, bad);
    check("ov_bad", 64'(bad), 64'd0);
    check("ov_err", 64'(wr_err), 64'd1);
    check("ov_npop", 64'(n_pop - p0), 64'd128);
    check("ov_hold", 64'(got[256]), 64'h10FF);
    wr_ptr = rd_ptr;

    // busy falls early
    push(128, 16'h2000);
    start_job(32'h11, 32'd1);
    check("sh_errclr", 64'(wr_err), 64'd0);
    sd_sector(200, 16'h2000, 1'b0, bad);
    check("sh_err", 64'(wr_err), 64'd1);
    wr_ptr = rd_ptr;

    // zero-count job
    s0 = n_start;
    start_job(32'h777, 32'd0);
    @(negedge clk);
    check("z_fin", 64'(Write_finish), 64'd1);
    check("z_err", 64'(wr_err), 64'd0);
    check("z_nstart", 64'(n_start - s0), 64'd0);

    // start edge during transfer is ignored
    push(128, 16'h3000);
    s0 = n_start;
    start_job(32'h55, 32'd1);
    sd_sector(256, 16'h3000, 1'b1, bad);
    check("mid_bad", 64'(bad), 64'd0);
    check("mid_addr", 64'(got_addr), 64'h55);
    check("mid_nstart", 64'(n_start - s0), 64'd1);
    check("mid_fin", 64'(Write_finish), 64'd1);
    check("mid_err", 64'(wr_err), 64'd0);

    // reset in the middle of a transfer
    push(256, 16'h4000);
    start_job(32'h200, 32'd2);
    wait_start();
    @(negedge clk);
    wr_busy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      wr_req = 1'b1;
      @(negedge clk);
      wr_req = 1'b0;
    end
    @(negedge clk);
    wr_req = 1'b1;
    rst_n  = 1'b0;
    #1;
    check("r_pop", 64'(fifo_rd_en), 64'd0);
    check("r_start", 64'(wr_start_en), 64'd0);
    check("r_data", 64'(wr_data), 64'd0);
    check("r_addr", 64'(wr_sec_addr), 64'd0);
    check("r_fin", 64'(Write_finish), 64'd0);
    check("r_err", 64'(wr_err), 64'd0);
    wr_req  = 1'b0;
    wr_busy = 1'b0;
    @(negedge clk);
    wr_ptr = rd_ptr;
    rst_n  = 1'b1;
    push(128, 16'h5000);
    s0 = n_start;
    start_job(32'h300, 32'd1);
    sd_sector(256, 16'h5000, 1'b0, bad);
    check("r2_bad", 64'(bad), 64'd0);
    check("r2_addr", 64'(got_addr), 64'h300);
    check("r2_nstart", 64'(n_start - s0), 64'd1);
    check("r2_fin", 64'(Write_finish), 64'd1);
    check("r2_err", 64'(wr_err), 64'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_write_sectors.md
Name: sd_write_sectors

Overview:
DMA-driven SD-card sector writer, the write-direction counterpart of the sector reader.
- On a start request it writes a contiguous run of 512-byte sectors to the card.
- Data is pulled from a show-ahead (FWFT) FIFO of DW-bit words and fed as 16-bit halfwords to the write interface of sd_ctrl_top (wr_start_en/wr_sec_addr/wr_busy/wr_req/wr_data).
- Sits in the clk_50m domain beside the reader. The top level synchronizes Write_finish to sys_clk.

Parameters:
- DW, 32, FIFO word width; must be 32 (two halfwords per word).
- SEC_HW, 256, halfwords per sector (512 bytes).
- LVL_W, 10, width of fifo_level input.

Ports:
- clk  in  1  SD reference clock (clk_50m).
- rst_n  in  1  asynchronous active-low reset.
- dma_sec_addr  in  32  first sector address; sampled at start.
- dma_sec_counts  in  32  number of sectors; sampled at start.
- dma_sd_write  in  1  start request; rising edge starts a job.
- fifo_rd_data  in  DW  FWFT FIFO head word.
- fifo_empty  in  1  FIFO empty.
- fifo_level  in  LVL_W  words currently in FIFO.
- fifo_rd_en  out  1  pop FIFO head (1-cycle pulse).
- wr_busy  in  1  from sd_ctrl_top; high during a sector write.
- wr_req  in  1  from sd_ctrl_top; 1-cycle request for next halfword.
- wr_start_en  out  1  1-cycle pulse starting a sector write.
- wr_sec_addr  out  32  sector address, stable from the wr_start_en pulse until wr_busy falls.
- wr_data  out  16  halfword to SD controller.
- Write_finish  out  1  job-complete level.
- wr_err  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0. State = IDLE, hw_sel = 0, counters 0.
- Start detection: dma_sd_write is registered once. A rising edge is recognized only in IDLE or DONE; edges in any other state are ignored.
- On a recognized start:
  - cur_addr <= dma_sec_addr, remain <= dma_sec_counts.
  - Write_finish <= 0, wr_err <= 0.
  - If dma_sec_counts == 0, go to DONE on the next cycle. Otherwise go to WAIT_DATA.
- States:
  - IDLE: wait for start.
  - WAIT_DATA: wait until fifo_level >= SEC_HW*16/DW (128), i.e. a full sector is buffered. No mid-sector underrun is expected.
  - START: wr_start_en = 1 for exactly one cycle, wr_sec_addr = cur_addr, hw_cnt <= 0. Then go to WAIT_BUSY.
  - WAIT_BUSY: wait for wr_busy == 1, then go to XFER.
  - XFER, per wr_req:
    - hw_sel == 0: wr_data <= fifo_rd_data[31:16], hw_sel <= 1.
    - hw_sel == 1: wr_data <= fifo_rd_data[15:0], fifo_rd_en pulses in the same cycle, hw_sel <= 0.
    - hw_cnt increments on each wr_req.
    - wr_data is registered: valid the cycle after wr_req and held until the next update.
  - XFER exit: on the wr_busy falling edge (registered copy), cur_addr <= cur_addr + 1 (wraps mod 2^32) and remain <= remain - 1. If remain == 1, go to DONE; otherwise go to WAIT_DATA.
  - DONE: Write_finish = 1, held until the next recognized start.
- Error conditions (set wr_err; sticky until next start):
  - wr_req when hw_cnt == SEC_HW: no pop, wr_data unchanged.
  - Pop attempted while fifo_empty: fifo_rd_en is suppressed.
  - wr_busy falls with hw_cnt != SEC_HW.
- Simultaneous events: wr_req in the same cycle as the wr_busy fall is serviced before the state exit.
- Reset mid-operation: immediate return to reset values. No wr_start_en or fifo_rd_en is issued after rst_n falls.

Decomposition:
- Shared package sd_pkg:
  - state enum (IDLE, WAIT_DATA, START, WAIT_BUSY, XFER, DONE);
  - SEC_HW, SEC_WORDS = SEC_HW*16/DW.
- One natural sub-module: sd_word_to_hw.
  - Owns the 32->16 halfword splitter: hw_sel, wr_data register, fifo_rd_en generation, underrun detect.
  - Driven by wr_req and an enable from the FSM.

Test Plan:
- Single sector: addr=0x100, count=1, FIFO preloaded with 128 words 0x00010002... →
  - one wr_start_en with wr_sec_addr=0x100;
  - wr_data sequence 0x0001, 0x0002, ... across 256 wr_req;
  - 128 fifo_rd_en pulses;
  - Write_finish=1, wr_err=0.
- Multi-sector: addr=0xFFFFFFFE, count=3 →
  - wr_sec_addr 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000;
  - 3 start pulses; Write_finish only after the third wr_busy fall.
- Data starvation: count=2, only 128 words buffered, 128 more added 1000 cycles later → second wr_start_en not issued until fifo_level>=128; no wr_err.
- Protocol errors: 257th wr_req in a sector → wr_err=1, no extra pop. Separately, wr_busy falls after 200 wr_req → wr_err=1.
- count=0, then a dma_sd_write edge during XFER of a later job → Write_finish=1 within 2 cycles with no wr_start_en; the mid-job edge is ignored and the job completes normally.
- rst_n asserted mid-XFER → all outputs 0 immediately; a fresh job afterwards completes correctly.
